// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel serial ADC receiver: FSM encoding,
// default frame format and counter-width helpers.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } adc_state_e;

    localparam int DEF_LEAD_BITS = 4;
    localparam int DEF_DATA_W    = 12;

    function automatic int frame_bits(input int lead_bits, input int data_w);
        return lead_bits + data_w;
    endfunction

    // Width of a counter that must hold 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while enabled, parks it high
// when disabled, and flags the cycle before each rising/falling edge.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = cnt_w(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = wrap && !sclk;
    assign fall_tick = wrap && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_serial_rx_multi.sv
// Multi-channel serial ADC capture with valid/ready output and sticky overrun.
// Define ADC_AVG_EN to average 2^AVG_LOG2 frames per delivered sample set.
module adc_serial_rx_multi
    import adc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEAD_BITS = DEF_LEAD_BITS,
    parameter int CHANNELS  = 2,
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 4,
    parameter int AVG_LOG2  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cont_en,
    input  logic [CHANNELS-1:0]          sdata,
    output logic                         cs,
    output logic                         sclk,
    output logic [CHANNELS*DATA_W-1:0]   dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         ovr_clr
);

    localparam int FRAME_BITS = frame_bits(LEAD_BITS, DATA_W);
    localparam int BIT_W      = cnt_w(FRAME_BITS);
    localparam int QW         = cnt_w(QUIET_CYC);
    localparam int ACC_W      = DATA_W + AVG_LOG2;

    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return DATA_W'(sum >> AVG_LOG2);
    endfunction

    adc_state_e state_q, state_d;

    logic [BIT_W-1:0]          bit_cnt;
    logic [QW-1:0]             quiet_cnt;
    logic                      sclk_en;
    logic                      rise_tick;
    logic                      fall_tick_unused;
    logic                      last_rise;
    logic                      quiet_last;
    logic                      done_p1;
    logic [DATA_W-1:0]         shreg_p0 [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] frame_word;
    logic [CHANNELS*DATA_W-1:0] load_word;
    logic                      load;

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sclk_en),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick_unused)
    );

    assign last_rise  = rise_tick && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign quiet_last = (quiet_cnt == QW'(QUIET_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start || cont_en) state_d = ST_CONV;
            ST_CONV:  if (last_rise) state_d = ST_QUIET;
            ST_QUIET: if (quiet_last) state_d = cont_en ? ST_CONV : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cs      = (state_q != ST_CONV);
        sclk_en = (state_q == ST_CONV);
        busy    = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            done_p1   <= 1'b0;
        end else begin
            done_p1 <= last_rise;
            if (state_q != ST_CONV)  bit_cnt <= '0;
            else if (rise_tick)      bit_cnt <= bit_cnt + BIT_W'(1);
            if (state_q == ST_QUIET && !quiet_last) quiet_cnt <= quiet_cnt + QW'(1);
            else                                    quiet_cnt <= '0;
        end
    end

    // Stage p0: serial capture; leading bits fall off the top of the register.
    always_ff @(posedge clk) begin
        if (rise_tick) begin
            for (int k = 0; k < CHANNELS; k++)
                shreg_p0[k] <= {shreg_p0[k][DATA_W-2:0], sdata[k]};
        end
    end

    always_comb begin
        frame_word = '0;
        for (int k = 0; k < CHANNELS; k++)
            frame_word[k*DATA_W +: DATA_W] = shreg_p0[k];
    end

`ifdef ADC_AVG_EN
    logic [ACC_W-1:0]    acc [CHANNELS];
    logic [AVG_LOG2-1:0] avg_cnt;
    logic                avg_start;

    assign avg_start = (state_q == ST_IDLE) && (state_d == ST_CONV);
    assign load      = done_p1 && (&avg_cnt);

    always_ff @(posedge clk) begin
        if (rst || avg_start) begin
            avg_cnt <= '0;
            for (int k = 0; k < CHANNELS; k++) acc[k] <= '0;
        end else if (done_p1) begin
            avg_cnt <= avg_cnt + AVG_LOG2'(1);
            for (int k = 0; k < CHANNELS; k++)
                acc[k] <= (&avg_cnt) ? '0 : acc[k] + ACC_W'(frame_word[k*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        load_word = '0;
        for (int k = 0; k < CHANNELS; k++)
            load_word[k*DATA_W +: DATA_W] =
                avg_trunc(acc[k] + ACC_W'(frame_word[k*DATA_W +: DATA_W]));
    end
`else
    assign load      = done_p1;
    assign load_word = frame_word;
`endif

    // Stage p1: output register; a completing frame always wins over a consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                dout       <= load_word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (load && dout_valid && !dout_ready) overrun <= 1'b1;
            else if (ovr_clr)                      overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// Self-checking bench for adc_serial_rx_multi: an ADC model shifts planned or
// random samples out on sclk falling edges; checks use a queue of sent frames.
module tb_adc_serial_rx_multi;

    localparam int DW = 12;
    localparam int LB = 4;
    localparam int CH = 2;
    localparam int CD = 2;
    localparam int QC = 4;
    localparam int AL = 2;
    localparam int FB = LB + DW;

    logic             clk = 1'b0;
    logic             rst, start, cont_en, dout_ready, ovr_clr;
    logic [CH-1:0]    sdata;
    logic             cs, sclk, dout_valid, busy, overrun;
    logic [CH*DW-1:0] dout;

    int n_vec = 0;
    int n_err = 0;

    logic [CH*DW-1:0] plan_q[$];
    logic [CH*DW-1:0] sent_q[$];

    always #5 clk = ~clk;

    adc_serial_rx_multi #(
        .DATA_W(DW), .LEAD_BITS(LB), .CHANNELS(CH),
        .CLK_DIV(CD), .QUIET_CYC(QC), .AVG_LOG2(AL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont_en(cont_en), .sdata(sdata),
        .cs(cs), .sclk(sclk), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    // Frame bit i (MSB first) of {LB zeros, sample}.
    function automatic logic adc_bit(input logic [DW-1:0] s, input int i);
        if (i < LB) return 1'b0;
        return s[DW-1-(i-LB)];
    endfunction

    // ADC model: picks a sample set at cs fall, drives one bit after each sclk fall.
    initial begin
        logic [CH*DW-1:0] w;
        sdata = '0;
        forever begin
            @(negedge cs);
            if (plan_q.size() > 0) w = plan_q.pop_front();
            else for (int k = 0; k < CH; k++) w[k*DW +: DW] = DW'($urandom);
            sent_q.push_back(w);
            for (int i = 0; i < FB; i++) begin
                @(negedge sclk or posedge cs);
                if (cs) break;
                for (int k = 0; k < CH; k++) sdata[k] = adc_bit(w[k*DW +: DW], i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs(input string tag, input logic lvl, output int n);
        n = 0;
        while (cs !== lvl && n < 400) begin
            tick();
            n++;
        end
        chk(tag, cs, lvl);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n, len, rises, low;
        logic prev;
        logic [CH*DW-1:0] w, w2;

        rst = 1'b1; start = 1'b0; cont_en = 1'b0; dout_ready = 1'b0; ovr_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_cs", cs, 1'b1);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_dout", dout, '0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        tick();
        sent_q.delete();

`ifdef ADC_AVG_EN
        begin
            int s0 [4] = '{10, 11, 12, 13};
            int s1 [4] = '{100, 200, 300, 400};
            int sum0, sum1;
            sum0 = 0; sum1 = 0;
            for (int f = 0; f < 4; f++) begin
                plan_q.push_back({DW'(s1[f]), DW'(s0[f])});
                sum0 += s0[f];
                sum1 += s1[f];
            end
            cont_en = 1'b1;
            for (int f = 0; f < 4; f++) begin
                wait_cs("avg_fall", 1'b0, n);
                if (f == 3) cont_en = 1'b0;
                wait_cs("avg_rise", 1'b1, n);
                tick();
                chk("avg_valid", dout_valid, (f == 3) ? 1'b1 : 1'b0);
            end
            chk("avg_ch0", dout[DW-1:0], sum0 / 4);
            chk("avg_ch1", dout[2*DW-1:DW], sum1 / 4);
            chk("avg_overrun", overrun, 1'b0);
            wait_idle("avg_idle");
        end
`else
        // Single shot with known samples
        plan_q.push_back({12'h3F0, 12'hA5C});
        pulse_start();
        chk("ss_cs_fall", cs, 1'b0);
        chk("ss_busy", busy, 1'b1);
        len = 0; rises = 0; prev = sclk;
        while (cs === 1'b0 && len < 400) begin
            len++;
            tick();
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
        end
        chk("ss_cs_low_len", len, 2 * CD * FB);
        chk("ss_sclk_rises", rises, FB);
        chk("ss_valid_at_cs_rise", dout_valid, 1'b0);
        tick();
        w = sent_q.pop_front();
        chk("ss_valid", dout_valid, 1'b1);
        chk("ss_dout", dout, 24'h3F0A5C);
        repeat (QC - 1) tick();
        chk("ss_idle_after_quiet", busy, 1'b0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("ss_consume", dout_valid, 1'b0);

        // Continuous, always ready; start pulse and cont_en drop during the last frame
        dout_ready = 1'b1;
        cont_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_cs("cont_fall", 1'b0, n);
            if (f > 0) chk("cont_quiet_gap", n + 1, QC);
            if (f == 2) begin
                repeat (10) tick();
                cont_en = 1'b0;
                pulse_start();
            end
            wait_cs("cont_rise", 1'b1, n);
            tick();
            w = sent_q.pop_front();
            chk("cont_valid", dout_valid, 1'b1);
            chk("cont_dout", dout, w);
            chk("cont_overrun", overrun, 1'b0);
        end
        wait_idle("cont_idle");
        low = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cs === 1'b0) low++;
        end
        chk("no_extra_frame", low, 0);
        chk("cont_consumed", dout_valid, 1'b0);

        // Overrun: two frames with no consumer
        dout_ready = 1'b0;
        cont_en = 1'b1;
        wait_cs("ovr_a_fall", 1'b0, n);
        wait_cs("ovr_a_rise", 1'b1, n);
        tick();
        w = sent_q.pop_front();
        chk("ovr_a_dout", dout, w);
        chk("ovr_a_overrun", overrun, 1'b0);
        wait_cs("ovr_b_fall", 1'b0, n);
        cont_en = 1'b0;
        wait_cs("ovr_b_rise", 1'b1, n);
        tick();
        w2 = sent_q.pop_front();
        chk("ovr_b_overrun", overrun, 1'b1);
        chk("ovr_b_newest", dout, w2);
        chk("ovr_b_valid", dout_valid, 1'b1);
        wait_idle("ovr_idle");
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 1'b0);
        chk("ovr_dout_stable", dout, w2);

        // Set event beats a simultaneous ovr_clr
        pulse_start();
        wait_cs("setwin_rise", 1'b1, n);
        ovr_clr = 1'b1;
        tick();
        chk("setwin_overrun", overrun, 1'b1);
        tick();
        ovr_clr = 1'b0;
        chk("setwin_then_clr", overrun, 1'b0);
        w = sent_q.pop_front();
        chk("setwin_dout", dout, w);
        wait_idle("setwin_idle");

        // Ready in the completion cycle counts as consume
        pulse_start();
        wait_cs("rdy_rise", 1'b1, n);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        w = sent_q.pop_front();
        chk("rdy_valid", dout_valid, 1'b1);
        chk("rdy_dout", dout, w);
        chk("rdy_overrun", overrun, 1'b0);
        tick();
        chk("rdy_valid_held", dout_valid, 1'b1);
        wait_idle("rdy_idle");

        // Reset at bit 7 of a frame
        pulse_start();
        rises = 0; prev = sclk; n = 0;
        while (rises < 7 && n < 400) begin
            tick();
            n++;
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
        end
        chk("mid_rst_reached_bit7", rises, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cs", cs, 1'b1);
        chk("mid_rst_sclk", sclk, 1'b1);
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_dout", dout, '0);
        tick();
        chk("mid_rst_no_load", dout_valid, 1'b0);
        sent_q.delete();
        plan_q.push_back({12'h123, 12'hFED});
        pulse_start();
        wait_cs("post_rst_rise", 1'b1, n);
        tick();
        chk("post_rst_dout", dout, 24'h123FED);
        chk("post_rst_valid", dout_valid, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
